lc_line_responder: RTL and testbench



---
 rtl/lc_pkg.sv | 24 ++
 rtl/lc_resp_fifo.sv | 85 ++++++++
 rtl/lc_line_responder.sv | 94 +++++++++
 tb/tb_lc_line_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc_pkg.sv
// Shared types and helpers for the lower-cache line responder.
// The fill entry type and the line-alignment helper are sized by the package widths.
package lc_pkg;

  localparam int LC_PADDR_BITS = 22;
  localparam int LC_LINE_BITS  = 512;

  typedef struct packed {
    logic [LC_PADDR_BITS-1:0] addr;
    logic [LC_LINE_BITS-1:0]  data;
  } lc_resp_t;

  // Clears the low off_bits of a byte address, giving the line base address.
  function automatic logic [LC_PADDR_BITS-1:0] line_align(
    input logic [LC_PADDR_BITS-1:0] addr,
    input int                       off_bits
  );
    logic [LC_PADDR_BITS-1:0] mask;
    mask = '1;
    mask = mask << off_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/lc_resp_fifo.sv
// Countdown FIFO of queued read fills: each entry ages from LATENCY-1 to 0
// and the head is presented only once its count has expired.
module lc_resp_fifo
  import lc_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_push,
  input  lc_resp_t i_push_ent,
  input  logic     i_resp_ready,
  output logic     o_ready,
  output logic     o_valid,
  output lc_resp_t o_head
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  lc_resp_t              r_mem     [FIFO_DEPTH];
  logic [CNT_W-1:0]      r_cnt     [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_occ_vec;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;

  logic                  w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready depends only on registered occupancy, so a pop frees space one cycle later.
  assign o_ready = (r_occ < OCC_FULL);
  assign o_valid = r_occ_vec[r_rd_ptr] && (r_cnt[r_rd_ptr] == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_pop   = o_valid && i_resp_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ_vec <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (r_occ_vec[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
      // The push slot is always empty, so it never collides with the popped head.
      if (i_push) begin
        r_occ_vec[r_wr_ptr] <= 1'b1;
        r_cnt[r_wr_ptr]     <= CNT_INIT;
        r_wr_ptr            <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_occ_vec[r_rd_ptr] <= 1'b0;
        r_rd_ptr            <= ptr_inc(r_rd_ptr);
      end
      if (i_push && !w_pop) begin
        r_occ <= r_occ + OCC_W'(1);
      end else if (!i_push && w_pop) begin
        r_occ <= r_occ - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_ent;
    end
  end

endmodule

// File: rtl/lc_line_responder.sv
// Lower-cache stand-in for the L1D: a direct-mapped line store with write-back
// accept, read lookup at accept time, and fixed-latency in-order fills.
module lc_line_responder
  import lc_pkg::*;
#(
  parameter int PADDR_BITS = LC_PADDR_BITS,
  parameter int B          = LC_LINE_BITS / 8,
  parameter int LINES      = 64,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [PADDR_BITS-1:0] req_addr_in,
  input  logic [8*B-1:0]        req_value_in,
  input  logic                  req_we_in,
  output logic                  resp_valid_out,
  input  logic                  resp_ready_in,
  output logic [PADDR_BITS-1:0] resp_addr_out,
  output logic [8*B-1:0]        resp_value_out
);

  localparam int OFF    = $clog2(B);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = PADDR_BITS - OFF - IDX_W;
  localparam int LINE_W = 8 * B;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINE_W-1:0] r_data [LINES];

  logic              w_fifo_ready;
  logic              w_accept;
  logic              w_wr;
  logic              w_rd;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  lc_resp_t          w_push_ent;
  logic              w_head_vld;
  lc_resp_t          w_head;

  assign w_accept = req_valid_in && w_fifo_ready;
  assign w_wr     = w_accept && req_we_in;
  assign w_rd     = w_accept && !req_we_in;
  assign w_idx    = req_addr_in[OFF +: IDX_W];
  assign w_tag    = req_addr_in[PADDR_BITS-1 -: TAG_W];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // A miss or alias reads as fresh (zeroed) memory and leaves the store untouched.
  always_comb begin
    w_push_ent      = '0;
    w_push_ent.addr = line_align(req_addr_in, OFF);
    w_push_ent.data = w_hit ? r_data[w_idx] : '0;
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_valid <= '0;
    end else if (w_wr) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_wr) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= req_value_in;
    end
  end

  lc_resp_fifo #(
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .i_clk        (clk_in),
    .i_rst_n      (rst_N_in),
    .i_push       (w_rd),
    .i_push_ent   (w_push_ent),
    .i_resp_ready (resp_ready_in),
    .o_ready      (w_fifo_ready),
    .o_valid      (w_head_vld),
    .o_head       (w_head)
  );

  // Fill outputs read as zero whenever no fill is being presented.
  assign req_ready_out  = w_fifo_ready;
  assign resp_valid_out = w_head_vld;
  assign resp_addr_out  = w_head_vld ? w_head.addr : '0;
  assign resp_value_out = w_head_vld ? w_head.data : '0;

endmodule

// File: tb/tb_lc_line_responder.sv
// Scoreboard bench for lc_line_responder: directed scenarios plus randomized
// traffic against a line-level store model, with fills checked by a monitor.
module tb_lc_line_responder;

  localparam int LAT = 4;

  logic         clk_in = 1'b0;
  logic         rst_N_in = 1'b1;
  logic         req_valid_in = 1'b0;
  logic         req_ready_out;
  logic [21:0]  req_addr_in = '0;
  logic [511:0] req_value_in = '0;
  logic         req_we_in = 1'b0;
  logic         resp_valid_out;
  logic         resp_ready_in = 1'b1;
  logic [21:0]  resp_addr_out;
  logic [511:0] resp_value_out;

  lc_line_responder dut (
    .clk_in         (clk_in),
    .rst_N_in       (rst_N_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .req_addr_in    (req_addr_in),
    .req_value_in   (req_value_in),
    .req_we_in      (req_we_in),
    .resp_valid_out (resp_valid_out),
    .resp_ready_in  (resp_ready_in),
    .resp_addr_out  (resp_addr_out),
    .resp_value_out (resp_value_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [21:0]  addr;
    logic [511:0] data;
    int           acc;
  } exp_t;
  exp_t exp_q[$];

  // Line-level memory model: one slot per index remembering which line lives there.
  bit           m_valid [64];
  logic [21:0]  m_laddr [64];
  logic [511:0] m_data  [64];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_accept(input bit we, input logic [21:0] a, input logic [511:0] v);
    int          idx;
    logic [21:0] la;
    exp_t        e;
    idx = int'(a[11:6]);
    la  = {a[21:6], 6'b0};
    if (we) begin
      m_valid[idx] = 1'b1;
      m_laddr[idx] = la;
      m_data[idx]  = v;
    end else begin
      e.addr = la;
      e.data = (m_valid[idx] && m_laddr[idx] == la) ? m_data[idx] : '0;
      e.acc  = cyc;
      exp_q.push_back(e);
    end
  endfunction

  task automatic send(input bit we, input logic [21:0] addr, input logic [511:0] val);
    bit done;
    bit rdy;
    done = 1'b0;
    req_valid_in = 1'b1;
    req_we_in    = we;
    req_addr_in  = addr;
    req_value_in = val;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk_in);
      rdy = req_ready_out && rst_N_in;
      @(posedge clk_in);
      if (rdy) done = 1'b1;
    end
    #1;
    req_valid_in = 1'b0;
    req_we_in    = 1'b0;
    if (done) model_accept(we, addr, val);
    else begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted addr=%0h", addr);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk_in);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [511:0] rnd_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Monitor: pops the scoreboard on every accepted fill and checks held outputs stay put.
  exp_t         mon_e;
  bit           hold = 1'b0;
  logic [21:0]  h_addr;
  logic [511:0] h_data;
  always @(negedge clk_in) begin
    if (!rst_N_in) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", {511'b0, resp_valid_out}, 512'd1);
        chk("hold_addr", {490'b0, resp_addr_out}, {490'b0, h_addr});
        chk("hold_data", resp_value_out, h_data);
      end
      if (resp_valid_out && resp_ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp actual_addr=%0h required=no_fill", resp_addr_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_addr", {490'b0, resp_addr_out}, {490'b0, mon_e.addr});
          chk("resp_data", resp_value_out, mon_e.data);
          chk("resp_latency", {511'b0, (cyc - mon_e.acc) >= (LAT - 1)}, 512'd1);
        end
      end
      hold   = resp_valid_out && !resp_ready_in;
      h_addr = resp_addr_out;
      h_data = resp_value_out;
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  bit rnd_run;

  initial begin
    model_clear();
    #2 rst_N_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_ready", {511'b0, req_ready_out}, 512'd1);
    chk("rst_valid", {511'b0, resp_valid_out}, 512'd0);
    chk("rst_addr", {490'b0, resp_addr_out}, 512'd0);
    chk("rst_value", resp_value_out, 512'd0);
    rst_N_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Cold read: exact latency, zero data.
    send(1'b0, 22'h60300, '0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_in);
      chk("cold_latency", {511'b0, resp_valid_out}, (k == 4) ? 512'd1 : 512'd0);
    end
    wait_drain();

    // Write then read of another byte in the same line.
    send(1'b1, 22'h02000, 512'h12345678);
    send(1'b0, 22'h02010, '0);
    wait_drain();

    // Alias: same index, different tag.
    send(1'b1, 22'h04000, 512'hC0C0C0C0);
    send(1'b0, 22'h05000, '0);
    send(1'b0, 22'h04000, '0);
    wait_drain();

    // Full FIFO under backpressure.
    for (int i = 0; i < 4; i++) send(1'b1, 22'h20040 + 22'(i * 64), {16{32'(i + 1)}});
    resp_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 22'h20040 + 22'(i * 64), '0);
    chk("full_ready_low", {511'b0, req_ready_out}, 512'd0);
    repeat (10) @(posedge clk_in);
    #1;
    chk("full_head_valid", {511'b0, resp_valid_out}, 512'd1);
    chk("full_ready_still_low", {511'b0, req_ready_out}, 512'd0);
    fork
      send(1'b0, 22'h20140, '0);
      begin
        resp_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk_in);
          chk("drain_valid", {511'b0, resp_valid_out}, 512'd1);
          if (k == 0) chk("ready_in_pop_cycle", {511'b0, req_ready_out}, 512'd0);
          if (k == 1) chk("ready_after_pop", {511'b0, req_ready_out}, 512'd1);
        end
      end
    join
    wait_drain();

    // Read then write to the same line on the next cycle.
    send(1'b0, 22'h03000, '0);
    send(1'b1, 22'h03000, 512'hAA);
    send(1'b0, 22'h03000, '0);
    wait_drain();

    // Reset while two reads are queued.
    send(1'b1, 22'h07000, {16{32'h5A5A0001}});
    resp_ready_in = 1'b0;
    send(1'b0, 22'h07000, '0);
    send(1'b0, 22'h08040, '0);
    repeat (4) @(posedge clk_in);
    #2;
    chk("pre_rst_valid", {511'b0, resp_valid_out}, 512'd1);
    rst_N_in = 1'b0;
    model_clear();
    #1;
    chk("rst_async_valid", {511'b0, resp_valid_out}, 512'd0);
    chk("rst_async_ready", {511'b0, req_ready_out}, 512'd1);
    repeat (2) @(posedge clk_in);
    #1;
    rst_N_in = 1'b1;
    resp_ready_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      chk("post_rst_quiet", {511'b0, resp_valid_out}, 512'd0);
    end
    @(posedge clk_in);
    #1;
    send(1'b0, 22'h07000, '0);
    wait_drain();

    // Randomized traffic with random fill backpressure.
    rnd_run = 1'b1;
    fork
      begin
        while (rnd_run) begin
          @(posedge clk_in);
          #1;
          resp_ready_in = ($urandom_range(0, 9) < 7);
        end
      end
      begin
        for (int n = 0; n < 300; n++) begin
          int unsigned gap;
          logic [21:0] a;
          a = 22'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 6) | $urandom_range(0, 63));
          send(($urandom_range(0, 2) == 0), a, rnd_line());
          gap = $urandom_range(0, 2);
          if (gap != 0) begin
            repeat (gap) @(posedge clk_in);
            #1;
          end
        end
        rnd_run = 1'b0;
      end
    join
    resp_ready_in = 1'b1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
